// File: rtl/xif_copro_pkg.sv
// xif_copro_pkg: shared coprocessor types and operand limits for the XIF issue queue
package xif_copro_pkg;
  localparam int RS_WIDTH_DEF = 32;
  localparam int NUM_RS_MIN = 2;
  localparam int NUM_RS_MAX = 3;
  typedef struct packed {
    logic [31:0] instr;
    logic        committed;
    logic        killed;
  } entry_t;
endpackage

// File: rtl/xif_id_match.sv
// xif_id_match: per-entry ID comparator returning a hit vector over live entries
module xif_id_match #(
  parameter int DEPTH = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic [DEPTH*ID_WIDTH-1:0] ids_i,
  input  logic [DEPTH-1:0]          valid_i,
  input  logic [ID_WIDTH-1:0]       id_i,
  output logic [DEPTH-1:0]          hit_o
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit_o[i] = valid_i[i] && (ids_i[i*ID_WIDTH +: ID_WIDTH] == id_i);
  end
endmodule

// File: rtl/xif_issue_queue.sv
// xif_issue_queue: in-order circular issue buffer holding XIF instructions until commit/kill
module xif_issue_queue
  import xif_copro_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_WIDTH = 4,
  parameter int NUM_RS = 2,
  parameter int RS_WIDTH = RS_WIDTH_DEF,
  parameter int COMMIT_BYPASS = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [31:0]                issue_instr_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  input  logic [NUM_RS*RS_WIDTH-1:0] issue_rs_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [ID_WIDTH-1:0]        out_id_o,
  output logic [NUM_RS*RS_WIDTH-1:0] out_rs_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  entry_t                     r_ent [DEPTH];
  logic [ID_WIDTH-1:0]        r_id  [DEPTH];
  logic [NUM_RS*RS_WIDTH-1:0] r_rs  [DEPTH];
  logic [PW-1:0]              r_head, r_tail;
  logic [PW:0]                r_count;
  logic [DEPTH*ID_WIDTH-1:0]  w_ids;
  logic [DEPTH-1:0]           w_live, w_hit;
  logic                       w_head_live, w_push, w_pop, w_byp;
  // an entry is live when its distance from head (mod DEPTH) is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_live
    assign w_live[i] = {1'b0, PW'(i) - r_head} < r_count;
    assign w_ids[i*ID_WIDTH +: ID_WIDTH] = r_id[i];
  end
  xif_id_match #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) u_match (
    .ids_i  (w_ids),
    .valid_i(w_live),
    .id_i   (commit_id_i),
    .hit_o  (w_hit)
  );
  assign w_head_live   = r_count != '0;
  assign issue_ready_o = r_count != (PW+1)'(DEPTH);
  assign out_valid_o   = w_head_live && r_ent[r_head].committed && !r_ent[r_head].killed;
  assign out_instr_o   = r_ent[r_head].instr;
  assign out_id_o      = r_id[r_head];
  assign out_rs_o      = r_rs[r_head];
  assign occupancy_o   = r_count;
  assign w_push = issue_valid_i && issue_ready_o;
  // pop decision uses registered flags, so a same-cycle commit never alters it
  assign w_pop  = (out_valid_o && out_ready_i) || (w_head_live && r_ent[r_head].killed);
  assign w_byp  = (COMMIT_BYPASS != 0) && commit_valid_i && (commit_id_i == issue_id_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].committed <= 1'b0;
        r_ent[i].killed    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && w_hit[i]) begin
          if (commit_kill_i) r_ent[i].killed <= 1'b1;
          else               r_ent[i].committed <= 1'b1;
        end
      end
      if (w_push) begin
        r_ent[r_tail] <= '{instr: issue_instr_i, committed: w_byp && !commit_kill_i, killed: w_byp && commit_kill_i};
        r_id[r_tail]  <= issue_id_i;
        r_rs[r_tail]  <= issue_rs_i;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_xif_issue_queue.sv
// tb_xif_issue_queue: random and directed checks of two queue instances (bypass on/off) against a queue model
module tb_xif_issue_queue;
  localparam int DEPTH = 4, IDW = 4, NRS = 2, RSW = 32;
  typedef struct {
    logic [31:0]        instr;
    logic [IDW-1:0]     id;
    logic [NRS*RSW-1:0] rs;
    bit                 c;
    bit                 k;
  } m_t;
  logic clk = 0, rst = 0, iv = 0, cv = 0, ck = 0, rdy = 0;
  logic [31:0] instr = 0;
  logic [IDW-1:0] id = 0, cid = 0;
  logic [NRS*RSW-1:0] rs = 0;
  logic rdy_a, ov_a, rdy_b, ov_b;
  logic [31:0] oi_a, oi_b;
  logic [IDW-1:0] oid_a, oid_b;
  logic [NRS*RSW-1:0] ors_a, ors_b;
  logic [2:0] occ_a, occ_b;
  m_t qa[$], qb[$];
  int errors = 0, checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  xif_issue_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .NUM_RS(NRS), .RS_WIDTH(RSW), .COMMIT_BYPASS(1)) u_a (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_ready_o(rdy_a), .issue_instr_i(instr),
    .issue_id_i(id), .issue_rs_i(rs), .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
    .out_valid_o(ov_a), .out_ready_i(rdy), .out_instr_o(oi_a), .out_id_o(oid_a), .out_rs_o(ors_a),
    .occupancy_o(occ_a));
  xif_issue_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .NUM_RS(NRS), .RS_WIDTH(RSW), .COMMIT_BYPASS(0)) u_b (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_ready_o(rdy_b), .issue_instr_i(instr),
    .issue_id_i(id), .issue_rs_i(rs), .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
    .out_valid_o(ov_b), .out_ready_i(rdy), .out_instr_o(oi_b), .out_id_o(oid_b), .out_rs_o(ors_b),
    .occupancy_o(occ_b));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference behaviour: commits mark matching queued entries, then head leaves, then the new entry joins
  task automatic step(input bit byp, input m_t qi[$], output m_t qo[$]);
    int sz;
    bit pop;
    qo = qi;
    if (rst) qo.delete();
    else begin
      sz = qo.size();
      pop = sz > 0 && (qo[0].k || (qo[0].c && rdy));
      if (cv) for (int i = 0; i < sz; i++) if (qo[i].id == cid) begin
        if (ck) qo[i].k = 1;
        else qo[i].c = 1;
      end
      if (pop) void'(qo.pop_front());
      if (iv && sz < DEPTH)
        qo.push_back('{instr, id, rs, byp && cv && cid == id && !ck, byp && cv && cid == id && ck});
    end
  endtask

  task automatic cmp(input string nm, input m_t qe[$], input logic [2:0] occ, input logic r, input logic v,
                     input logic [31:0] oi, input logic [IDW-1:0] oid, input logic [63:0] ors);
    bit ev;
    ev = qe.size() > 0 ? (qe[0].c && !qe[0].k) : 1'b0;
    chk({nm, "_occ"}, 64'(occ), 64'(qe.size()));
    chk({nm, "_ready"}, 64'(r), 64'(qe.size() != DEPTH));
    chk({nm, "_valid"}, 64'(v), 64'(ev));
    if (ev) begin
      chk({nm, "_instr"}, 64'(oi), 64'(qe[0].instr));
      chk({nm, "_id"}, 64'(oid), 64'(qe[0].id));
      chk({nm, "_rs"}, ors, qe[0].rs);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    cmp("a", qa, occ_a, rdy_a, ov_a, oi_a, oid_a, ors_a);
    cmp("b", qb, occ_b, rdy_b, ov_b, oi_b, oid_b, ors_b);
  end

  task automatic cyc(input bit i_v, input logic [IDW-1:0] i_id, input bit c_v, input logic [IDW-1:0] c_id,
                     input bit c_k, input bit o_r, input bit r);
    iv = i_v; id = i_id; cv = c_v; cid = c_id; ck = c_k; rdy = o_r; rst = r;
    instr = $urandom; rs = {$urandom, $urandom};
    @(posedge clk);
    #1;
    step(1'b1, qa, qa);
    step(1'b0, qb, qb);
    chk_en = 1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rst_occ", 64'(occ_a), 0); chk("rst_ready", 64'(rdy_a), 1); chk("rst_valid", 64'(ov_a), 0);
    for (int i = 0; i < 4; i++) cyc(1, IDW'(i), 0, 0, 0, 0, 0);
    chk("fill_occ", 64'(occ_a), 4); chk("fill_ready", 64'(rdy_a), 0); chk("fill_valid", 64'(ov_a), 0);
    cyc(0, 0, 1, 2, 0, 1, 0);
    chk("c2_valid", 64'(ov_a), 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("c0_valid", 64'(ov_a), 1); chk("c0_id", 64'(oid_a), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("id1_blocks", 64'(ov_a), 0); chk("pop0_occ", 64'(occ_a), 3);
    cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("bp_valid", 64'(ov_a), 1); chk("bp_id", 64'(oid_a), 1);
    end
    cyc(0, 0, 1, 3, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, IDW'(k + 4), 1, IDW'(k + 4), 0, 1, 0);
      chk("wrap_occ", 64'(occ_a), 3); chk("wrap_id", 64'(oid_a), 64'(k + 2));
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(1, 6, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 1, 1, 0);
    chk("kill_occ2", 64'(occ_a), 2); chk("kill_valid", 64'(ov_a), 0);
    cyc(0, 0, 1, 6, 0, 1, 0);
    chk("kill_occ1", 64'(occ_a), 1); chk("kill_v6", 64'(ov_a), 1); chk("kill_id6", 64'(oid_a), 6);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("kill_occ0", 64'(occ_a), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(1, 3, 1, 3, 0, 0, 0);
    chk("byp_on", 64'(ov_a), 1); chk("byp_off", 64'(ov_b), 0);
    for (int i = 0; i < 3; i++) cyc(1, IDW'(i + 8), 1, IDW'(i + 8), 0, 0, 0);
    chk("full_occ", 64'(occ_a), 4); chk("full_valid", 64'(ov_a), 1);
    cyc(1, 1, 0, 0, 0, 1, 1);
    chk("rfull_occ", 64'(occ_a), 0); chk("rfull_valid", 64'(ov_a), 0); chk("rfull_ready", 64'(rdy_a), 1);
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 9) < 6, IDW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          IDW'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 99) == 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
